dallanma_ongorucu: RTL and testbench
====================================

# dallanma_ongorucu

- Fetch-stage branch predictor. It consumes each fetched instruction word plus the predecoder's branch class (`dallanma_turu_t` from `oncoz_pkg`) and returns the same-cycle prediction: taken/not-taken and next PC.
- Execute reports resolved outcomes back. These train a 2-bit counter table and a small target buffer, and restore the return-address stack on mispredicts.
- It is the receiving end of the predecode classification.

## Interface
Parameters:
- BHT_BOYUT, 64: number of 2-bit counters; power of two.
- BTB_BOYUT, 16: JALR target buffer entries; power of two; direct-mapped.
- RAS_DERINLIK, 4: return stack depth; power of two.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- getir_gecerli_i  in  1  fetch slot valid; one accepted instruction per asserted cycle.
- getir_ps_i  in  32  fetch PC.
- buyruk_i  in  32  fetched instruction word.
- dallanma_turu_i  in  dallanma_turu_t  predecoded class.
- ongoru_atla_o  out  1  predicted taken.
- ongoru_hedef_o  out  32  predicted next PC.
- ras_durum_o  out  RAS_DW  RAS checkpoint {count, top pointer}, carried down the pipe; RAS_DW = 2·log2(RAS_DERINLIK)+1.
- guncelle_gecerli_i  in  1  execute resolution valid.
- guncelle_ps_i  in  32  resolved instruction PC.
- guncelle_tur_i  in  dallanma_turu_t  resolved class.
- guncelle_atladi_i  in  1  actually taken.
- guncelle_hedef_i  in  32  actual target.
- guncelle_yanlis_i  in  1  mispredicted; qualified by guncelle_gecerli_i.
- guncelle_ras_durum_i  in  RAS_DW  checkpoint of the mispredicted instruction.

## Operation
Outputs are combinational from the current state. Default, and whenever getir_gecerli_i=0: ongoru_atla_o=0, ongoru_hedef_o=getir_ps_i+4.

Prediction per class:
- DALLANMA: counter at index getir_ps_i[log2(BHT_BOYUT)+1:2]. Taken when counter ≥2; target = PC + sign-extended B-immediate.
- JAL: always taken; target = PC + sign-extended J-immediate. Push PC+4 when rd ∈ {x1,x5}.
- JALR: always taken.
  - Return (rs1 ∈ {x1,x5}, rd ∉ {x1,x5}) with RAS non-empty: target = RAS top; pop.
  - Otherwise the BTB supplies the target on a valid entry with matching tag (PC[31:log2(BTB_BOYUT)+2]). On a miss, not taken with PC+4.
  - rd ∈ {x1,x5} pushes PC+4.
  - rd and rs1 both links with rd≠rs1: pop then push.
- DALLANMA_YOK: default.

Counters:
- 2-bit saturating; reset value 2'b01.
- Update only for DALLANMA resolutions: +1 when taken, −1 when not, clamped to 0..3.

BTB:
- Written on resolved JALR with guncelle_hedef_i: tag replaced, valid set.
- Reset clears all valid bits.

RAS (circular):
- Push to a full stack overwrites the oldest entry; count saturates at RAS_DERINLIK.
- Pop on empty is not performed; the BTB path is used.

Mispredict recovery:
- guncelle_gecerli_i & guncelle_yanlis_i loads {count, pointer} from guncelle_ras_durum_i.
- This has priority over the same-cycle fetch push/pop, which is dropped.
- Entry contents are not restored.

## Timing
- Prediction latency 0 cycles. ras_durum_o reflects the state before this cycle's push/pop.
- Table/BTB/RAS writes take effect at the next rising edge.
- Same-cycle lookup and update to one index: the lookup sees the old value; no bypass.
- Reset, asynchronous at any time, restores:
  - all counters to 01;
  - BTB valids to 0;
  - RAS count and pointer to 0, entries to 0.
- Outputs then follow the default/prediction rules above immediately.

## Configuration
- ONGORUCU_RAS_EN defined: RAS as above.
- Undefined:
  - no stack storage;
  - JALR is always predicted through the BTB;
  - ras_durum_o is tied to 0 and guncelle_ras_durum_i is ignored.
- Ports are unchanged in both builds.

## Structure
- oncoz_pkg holds dallanma_turu_t (existing), the counter reset constant, ras_durum_t, and the link-register test function.
- Sub-module donus_adres_yigini implements the RAS, with push/pop/restore inputs and a top/state output. It is instantiated only under ONGORUCU_RAS_EN.

## Test plan
- After reset, BEQ at 0x100 with imm +16 → atla=0, hedef=0x104. Two taken updates → atla=1, hedef=0x110.
- Four not-taken updates from counter 3 → counter saturates at 0; a further decrement leaves it at 0.
- JAL x1 at 0x200 then JALR x0,0(x1) → JAL hedef=PC+imm; JALR hedef=0x204; count returns to 0.
- Five nested JAL x1 calls with depth 4, then five returns → first four pop correct addresses, fifth falls to the BTB/PC+4 path.
- Push in the same cycle as a mispredict restore with checkpoint {1,1} → ras_durum_o={1,1} next cycle and the push is dropped.
- JALR x0,0(x6) misses, then an update with target 0x4000 → next fetch at the same PC gives atla=1, hedef=0x4000. With ONGORUCU_RAS_EN undefined, the return case also uses the BTB.

Source files
------------

// File: rtl/oncoz_pkg.sv
// Shared fetch-side types: branch class, counter reset value, RAS checkpoint layout
// and the link-register test used by both prediction and RAS control.
package oncoz_pkg;

    typedef enum logic [1:0] {
        DALLANMA_YOK = 2'd0,
        DALLANMA     = 2'd1,
        JAL          = 2'd2,
        JALR         = 2'd3
    } dallanma_turu_t;

    localparam logic [1:0] SAYAC_SIFIRLAMA = 2'b01;

    // Checkpoint layout for the default depth of 4: {count, top pointer}.
    localparam int RAS_VARSAYILAN_IW = 2;

    typedef struct packed {
        logic [RAS_VARSAYILAN_IW:0]   sayi;
        logic [RAS_VARSAYILAN_IW-1:0] isaretci;
    } ras_durum_t;

    function automatic logic baglanti_mi(input logic [4:0] reg_no);
        return (reg_no == 5'd1) || (reg_no == 5'd5);
    endfunction

endpackage

// File: rtl/donus_adres_yigini.sv
// Circular return-address stack with a {count, top pointer} checkpoint that can be
// reloaded on a mispredict; entry contents are never rolled back.
module donus_adres_yigini
    import oncoz_pkg::*;
#(
    parameter int DERINLIK = 4,
    localparam int IW = $clog2(DERINLIK),
    localparam int DW = 2 * IW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          it,
    input  logic          cek,
    input  logic          geri_yukle,
    input  logic [31:0]   it_veri,
    input  logic [DW-1:0] geri_durum,
    output logic [31:0]   tepe,
    output logic [DW-1:0] durum
);

    logic [31:0]   yigin [DERINLIK];
    logic [IW:0]   sayi;
    logic [IW-1:0] isaretci;
    logic [IW-1:0] sonraki;
    logic          bos_degil;

    assign sonraki   = isaretci + IW'(1);
    assign bos_degil = (sayi != '0);
    assign tepe      = yigin[isaretci];
    assign durum     = {sayi, isaretci};

    // Restore wins over any same-cycle push/pop; a push to a full stack overwrites the oldest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sayi     <= '0;
            isaretci <= '0;
            for (int i = 0; i < DERINLIK; i++) begin
                yigin[i] <= '0;
            end
        end else if (geri_yukle) begin
            sayi     <= geri_durum[DW-1:IW];
            isaretci <= geri_durum[IW-1:0];
        end else if (it && cek && bos_degil) begin
            yigin[isaretci] <= it_veri;
        end else if (it) begin
            isaretci       <= sonraki;
            yigin[sonraki] <= it_veri;
            if (sayi != (IW+1)'(DERINLIK)) begin
                sayi <= sayi + (IW+1)'(1);
            end
        end else if (cek && bos_degil) begin
            isaretci <= isaretci - IW'(1);
            sayi     <= sayi - (IW+1)'(1);
        end
    end

endmodule

// File: rtl/dallanma_ongorucu.sv
// Fetch-stage branch predictor: 2-bit counter table, direct-mapped JALR target buffer and,
// when ONGORUCU_RAS_EN is defined, a return-address stack; trained by execute resolutions.
module dallanma_ongorucu
    import oncoz_pkg::*;
#(
    parameter int BHT_BOYUT    = 64,
    parameter int BTB_BOYUT    = 16,
    parameter int RAS_DERINLIK = 4,
    localparam int RAS_DW      = 2 * $clog2(RAS_DERINLIK) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              getir_gecerli_i,
    input  logic [31:0]       getir_ps_i,
    input  logic [31:0]       buyruk_i,
    input  dallanma_turu_t    dallanma_turu_i,
    output logic              ongoru_atla_o,
    output logic [31:0]       ongoru_hedef_o,
    output logic [RAS_DW-1:0] ras_durum_o,
    input  logic              guncelle_gecerli_i,
    input  logic [31:0]       guncelle_ps_i,
    input  dallanma_turu_t    guncelle_tur_i,
    input  logic              guncelle_atladi_i,
    input  logic [31:0]       guncelle_hedef_i,
    input  logic              guncelle_yanlis_i,
    input  logic [RAS_DW-1:0] guncelle_ras_durum_i
);

    localparam int BHT_IW = $clog2(BHT_BOYUT);
    localparam int BTB_IW = $clog2(BTB_BOYUT);
    localparam int ETIKET_W = 30 - BTB_IW;

    logic [1:0]          bht [BHT_BOYUT];
    logic [BTB_BOYUT-1:0] btb_gecerli;
    logic [ETIKET_W-1:0] btb_etiket [BTB_BOYUT];
    logic [31:0]         btb_hedef [BTB_BOYUT];

    logic [4:0]        rd;
    logic [31:0]       b_imm;
    logic [31:0]       j_imm;
    logic [31:0]       ardisik;
    logic [BHT_IW-1:0] bht_idx;
    logic [BTB_IW-1:0] btb_idx;
    logic              btb_isabet;
    logic [BHT_IW-1:0] g_bht_idx;
    logic [BTB_IW-1:0] g_btb_idx;

    logic              ras_it;
    logic              ras_cek;
    logic              ras_geri;
    logic              ras_cek_uygun;
    logic [31:0]       ras_tepe;
    logic [RAS_DW-1:0] ras_durum;

    assign rd      = buyruk_i[11:7];
    assign b_imm   = {{20{buyruk_i[31]}}, buyruk_i[7], buyruk_i[30:25], buyruk_i[11:8], 1'b0};
    assign j_imm   = {{12{buyruk_i[31]}}, buyruk_i[19:12], buyruk_i[20], buyruk_i[30:21], 1'b0};
    assign ardisik = getir_ps_i + 32'd4;
    assign bht_idx = getir_ps_i[BHT_IW+1:2];
    assign btb_idx = getir_ps_i[BTB_IW+1:2];
    assign btb_isabet = btb_gecerli[btb_idx] && (btb_etiket[btb_idx] == getir_ps_i[31:BTB_IW+2]);
    assign g_bht_idx = guncelle_ps_i[BHT_IW+1:2];
    assign g_btb_idx = guncelle_ps_i[BTB_IW+1:2];
    assign ras_geri  = guncelle_gecerli_i & guncelle_yanlis_i;
    assign ras_durum_o = ras_durum;

    // A JALR that cannot pop a return address falls back to the BTB, and a BTB miss predicts fall-through.
    always_comb begin
        ongoru_atla_o  = 1'b0;
        ongoru_hedef_o = ardisik;
        ras_it         = 1'b0;
        ras_cek        = 1'b0;
        if (getir_gecerli_i) begin
            unique case (dallanma_turu_i)
                DALLANMA: begin
                    if (bht[bht_idx][1]) begin
                        ongoru_atla_o  = 1'b1;
                        ongoru_hedef_o = getir_ps_i + b_imm;
                    end
                end
                JAL: begin
                    ongoru_atla_o  = 1'b1;
                    ongoru_hedef_o = getir_ps_i + j_imm;
                    ras_it         = baglanti_mi(rd);
                end
                JALR: begin
                    if (ras_cek_uygun) begin
                        ongoru_atla_o  = 1'b1;
                        ongoru_hedef_o = ras_tepe;
                        ras_cek        = 1'b1;
                    end else if (btb_isabet) begin
                        ongoru_atla_o  = 1'b1;
                        ongoru_hedef_o = btb_hedef[btb_idx];
                    end
                    ras_it = baglanti_mi(rd);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_BOYUT; i++) begin
                bht[i] <= SAYAC_SIFIRLAMA;
            end
        end else if (guncelle_gecerli_i && (guncelle_tur_i == DALLANMA)) begin
            if (guncelle_atladi_i && (bht[g_bht_idx] != 2'b11)) begin
                bht[g_bht_idx] <= bht[g_bht_idx] + 2'd1;
            end else if (!guncelle_atladi_i && (bht[g_bht_idx] != 2'b00)) begin
                bht[g_bht_idx] <= bht[g_bht_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btb_gecerli <= '0;
            for (int i = 0; i < BTB_BOYUT; i++) begin
                btb_etiket[i] <= '0;
                btb_hedef[i]  <= '0;
            end
        end else if (guncelle_gecerli_i && (guncelle_tur_i == JALR)) begin
            btb_gecerli[g_btb_idx] <= 1'b1;
            btb_etiket[g_btb_idx]  <= guncelle_ps_i[31:BTB_IW+2];
            btb_hedef[g_btb_idx]   <= guncelle_hedef_i;
        end
    end

`ifdef ONGORUCU_RAS_EN
    logic [4:0] rs1;
    logic       ras_bos_degil;

    assign rs1 = buyruk_i[19:15];
    assign ras_bos_degil = (ras_durum[RAS_DW-1 -: ($clog2(RAS_DERINLIK) + 1)] != '0);
    // Pure returns and link-swapping coroutine calls pop; rd == rs1 link is a plain call.
    assign ras_cek_uygun = baglanti_mi(rs1) && (!baglanti_mi(rd) || (rd != rs1)) && ras_bos_degil;

    donus_adres_yigini #(
        .DERINLIK (RAS_DERINLIK)
    ) u_ras (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .it         (ras_it),
        .cek        (ras_cek),
        .geri_yukle (ras_geri),
        .it_veri    (ardisik),
        .geri_durum (guncelle_ras_durum_i),
        .tepe       (ras_tepe),
        .durum      (ras_durum)
    );
`else
    logic unused_ras;

    assign ras_cek_uygun = 1'b0;
    assign ras_tepe      = '0;
    assign ras_durum     = '0;
    assign unused_ras    = ^{ras_it, ras_cek, ras_geri, guncelle_ras_durum_i};
`endif

    logic unused_bits;
    assign unused_bits = ^{buyruk_i[6:0], guncelle_ps_i[1:0]};

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Scoreboard bench for dallanma_ongorucu; expectations follow ONGORUCU_RAS_EN when it is defined.
module tb_dallanma_ongorucu;
    import oncoz_pkg::*;

    localparam int RAS_DW = 5;
`ifdef ONGORUCU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    localparam logic [31:0] BEQ_P16  = 32'h00208863;
    localparam logic [31:0] BEQ_M8   = 32'hFE000CE3;
    localparam logic [31:0] JAL_X1   = 32'h040000EF;
    localparam logic [31:0] JALR_RET = 32'h00008067;
    localparam logic [31:0] JALR_X6  = 32'h00030067;

    logic              clk;
    logic              rst_n;
    logic              getir_gecerli;
    logic [31:0]       getir_ps;
    logic [31:0]       buyruk;
    dallanma_turu_t    dallanma_turu;
    logic              ongoru_atla;
    logic [31:0]       ongoru_hedef;
    logic [RAS_DW-1:0] ras_durum;
    logic              guncelle_gecerli;
    logic [31:0]       guncelle_ps;
    dallanma_turu_t    guncelle_tur;
    logic              guncelle_atladi;
    logic [31:0]       guncelle_hedef;
    logic              guncelle_yanlis;
    logic [RAS_DW-1:0] guncelle_ras_durum;

    dallanma_ongorucu dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .getir_gecerli_i      (getir_gecerli),
        .getir_ps_i           (getir_ps),
        .buyruk_i             (buyruk),
        .dallanma_turu_i      (dallanma_turu),
        .ongoru_atla_o        (ongoru_atla),
        .ongoru_hedef_o       (ongoru_hedef),
        .ras_durum_o          (ras_durum),
        .guncelle_gecerli_i   (guncelle_gecerli),
        .guncelle_ps_i        (guncelle_ps),
        .guncelle_tur_i       (guncelle_tur),
        .guncelle_atladi_i    (guncelle_atladi),
        .guncelle_hedef_i     (guncelle_hedef),
        .guncelle_yanlis_i    (guncelle_yanlis),
        .guncelle_ras_durum_i (guncelle_ras_durum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic              atla;
        logic [31:0]       hedef;
        logic [RAS_DW-1:0] durum;
    } beklenen_t;

    beklenen_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [RAS_DW-1:0] ed(input int sayi, input int ptr);
        ras_durum_t d;
        d.sayi     = 3'(sayi);
        d.isaretci = 2'(ptr);
        if (RAS_ON) return d;
        return '0;
    endfunction

    task automatic endCycle();
        @(posedge clk);
        #1;
        getir_gecerli    = 1'b0;
        guncelle_gecerli = 1'b0;
        guncelle_yanlis  = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic gv, input logic [31:0] pc,
                                 input logic [31:0] instr, input dallanma_turu_t tur,
                                 input logic e_atla, input logic [31:0] e_hedef,
                                 input logic [RAS_DW-1:0] e_durum);
        beklenen_t b;
        getir_gecerli = gv;
        getir_ps      = pc;
        buyruk        = instr;
        dallanma_turu = tur;
        sb.push_back('{tag, e_atla, e_hedef, e_durum});
        #3;
        b = sb.pop_front();
        checkOutput({b.tag, ".atla"},  32'(ongoru_atla), 32'(b.atla));
        checkOutput({b.tag, ".hedef"}, ongoru_hedef,     b.hedef);
        checkOutput({b.tag, ".durum"}, 32'(ras_durum),   32'(b.durum));
        endCycle();
    endtask

    task automatic setUpdate(input dallanma_turu_t tur, input logic [31:0] ps,
                             input logic atladi, input logic [31:0] hedef);
        guncelle_gecerli = 1'b1;
        guncelle_tur     = tur;
        guncelle_ps      = ps;
        guncelle_atladi  = atladi;
        guncelle_hedef   = hedef;
    endtask

    task automatic applyUpdate(input dallanma_turu_t tur, input logic [31:0] ps,
                               input logic atladi, input logic [31:0] hedef);
        setUpdate(tur, ps, atladi, hedef);
        endCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] ret_hedef [5];
        logic        ret_atla  [5];
        int          ret_sayi  [5];
        int          ret_ptr   [5];
        ret_hedef = '{32'h344, 32'h334, 32'h324, 32'h314, 32'h404};
        ret_atla  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ret_sayi  = '{4, 3, 2, 1, 0};
        ret_ptr   = '{1, 0, 3, 2, 1};

        rst_n = 1'b0;
        getir_gecerli = 1'b0; getir_ps = '0; buyruk = '0; dallanma_turu = DALLANMA_YOK;
        guncelle_gecerli = 1'b0; guncelle_ps = '0; guncelle_tur = DALLANMA_YOK;
        guncelle_atladi = 1'b0; guncelle_hedef = '0; guncelle_yanlis = 1'b0;
        guncelle_ras_durum = '0;
        @(posedge clk);
        #1;

        applyStimulus("reset_idle", 1'b0, 32'h100, BEQ_P16, DALLANMA, 1'b0, 32'h104, ed(0, 0));
        applyStimulus("reset_beq",  1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b0, 32'h104, ed(0, 0));
        rst_n = 1'b1;

        applyStimulus("beq_init", 1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b0, 32'h104, ed(0, 0));
        applyUpdate(DALLANMA, 32'h100, 1'b1, 32'h110);
        applyStimulus("beq_ctr2", 1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b1, 32'h110, ed(0, 0));
        applyUpdate(DALLANMA, 32'h100, 1'b1, 32'h110);
        applyStimulus("beq_ctr3", 1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b1, 32'h110, ed(0, 0));
        for (int i = 0; i < 4; i++) applyUpdate(DALLANMA, 32'h100, 1'b0, 32'h104);
        applyStimulus("beq_sat0", 1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b0, 32'h104, ed(0, 0));
        applyUpdate(DALLANMA, 32'h100, 1'b1, 32'h110);
        applyStimulus("beq_ctr1", 1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b0, 32'h104, ed(0, 0));
        applyUpdate(DALLANMA, 32'h100, 1'b1, 32'h110);
        applyStimulus("beq_ctr2b", 1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b1, 32'h110, ed(0, 0));
        setUpdate(DALLANMA, 32'h100, 1'b0, 32'h104);
        applyStimulus("beq_nobypass", 1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b1, 32'h110, ed(0, 0));
        applyStimulus("beq_after", 1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b0, 32'h104, ed(0, 0));
        applyUpdate(DALLANMA, 32'h180, 1'b1, 32'h178);
        applyStimulus("beq_back", 1'b1, 32'h180, BEQ_M8, DALLANMA, 1'b1, 32'h178, ed(0, 0));

        applyStimulus("gv_low", 1'b0, 32'h200, JAL_X1, JAL, 1'b0, 32'h204, ed(0, 0));
        applyStimulus("jal_call", 1'b1, 32'h200, JAL_X1, JAL, 1'b1, 32'h240, ed(0, 0));
        applyStimulus("jalr_ret", 1'b1, 32'h240, JALR_RET, JALR,
                      RAS_ON, RAS_ON ? 32'h204 : 32'h244, ed(1, 1));
        applyStimulus("ret_count", 1'b0, 32'h0, 32'h0, DALLANMA_YOK, 1'b0, 32'h4, ed(0, 0));

        for (int k = 0; k < 5; k++) begin
            applyStimulus($sformatf("call%0d", k), 1'b1, 32'h300 + 32'(16 * k), JAL_X1, JAL,
                          1'b1, 32'h340 + 32'(16 * k), ed(k, k % 4));
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus($sformatf("ret%0d", k), 1'b1, 32'h400, JALR_RET, JALR,
                          RAS_ON ? ret_atla[k] : 1'b0, RAS_ON ? ret_hedef[k] : 32'h404,
                          ed(ret_sayi[k], ret_ptr[k]));
        end

        setUpdate(JAL, 32'h200, 1'b1, 32'h240);
        guncelle_yanlis    = 1'b1;
        guncelle_ras_durum = 5'b00101;
        applyStimulus("restore_push", 1'b1, 32'h500, JAL_X1, JAL, 1'b1, 32'h540, ed(0, 1));
        applyStimulus("restore_state", 1'b0, 32'h0, 32'h0, DALLANMA_YOK, 1'b0, 32'h4, ed(1, 1));
        applyStimulus("restore_top", 1'b1, 32'h600, JALR_RET, JALR,
                      RAS_ON, RAS_ON ? 32'h344 : 32'h604, ed(1, 1));

        setUpdate(JALR, 32'h700, 1'b1, 32'h4000);
        applyStimulus("btb_miss", 1'b1, 32'h700, JALR_X6, JALR, 1'b0, 32'h704, ed(0, 0));
        applyStimulus("btb_hit",  1'b1, 32'h700, JALR_X6, JALR, 1'b1, 32'h4000, ed(0, 0));
        applyStimulus("btb_tag",  1'b1, 32'h740, JALR_X6, JALR, 1'b0, 32'h744, ed(0, 0));
        applyStimulus("btb_ret",  1'b1, 32'h700, JALR_RET, JALR, 1'b1, 32'h4000, ed(0, 0));

        rst_n = 1'b0;
        applyStimulus("rst_bht", 1'b1, 32'h180, BEQ_M8, DALLANMA, 1'b0, 32'h184, ed(0, 0));
        applyStimulus("rst_btb", 1'b1, 32'h700, JALR_X6, JALR, 1'b0, 32'h704, ed(0, 0));
        rst_n = 1'b1;
        applyStimulus("post_rst", 1'b1, 32'h100, BEQ_P16, DALLANMA, 1'b0, 32'h104, ed(0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
